// File: rtl/fetch_queue.sv
// fetch_queue: decoupling FIFO between fetch and decode.
// Holds {pc, instruction, kanata id} triples in program order, stalls fetch
// when full, and discards everything on a branch redirect (flush).
module fetch_queue #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    // fetch side
    input  logic             valid_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      instr_i,
    input  logic [31:0]      kanata_id_i,
    input  logic             flush_i,
    output logic             stall_o,
    // decode side
    output logic             valid_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      instr_o,
    output logic [31:0]      kanata_id_o,
    input  logic             ready_i,
    // status
    output logic [PTR_W:0]   count_o,
    output logic [31:0]      flush_drops_o
);

    typedef logic [31:0] instruction_t;

    typedef struct packed {
        logic [31:0]  pc;
        instruction_t instr;
        logic [31:0]  kanata_id;
    } entry_t;

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [31:0]      flush_drops_q, flush_drops_d;

    logic full, empty, enq, deq;
    logic [32:0] drops_sum;

    // Handshake qualification and next-state computation.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        full  = (count_q == FULL_COUNT);
        empty = (count_q == '0);
        // A flush suppresses both the incoming instruction and the pop.
        enq   = valid_i & ~full & ~flush_i;
        deq   = ~empty & ready_i & ~flush_i;

        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        flush_drops_d = flush_drops_q;
        drops_sum     = {1'b0, flush_drops_q} + 33'(count_q);

        if (flush_i) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            flush_drops_d = drops_sum[32] ? '1 : drops_sum[31:0];
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (enq && !deq)      count_d = count_q + (PTR_W + 1)'(1);
            else if (deq && !enq) count_d = count_q - (PTR_W + 1)'(1);
        end
    end

    // Control state update; reset outranks flush and handshakes.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            flush_drops_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            flush_drops_q <= flush_drops_d;
        end
    end

    // Entry storage write at the tail.
    // NOTE: storage is deliberately not reset; valid_o masks stale entries, and a reset-free array maps onto RAM.
    always_ff @(posedge clk_i) begin
        if (!rst_i && enq) begin
            mem_q[wr_ptr_q] <= '{pc: pc_i, instr: instr_i, kanata_id: kanata_id_i};
        end
    end

    // Head presentation; outputs read zero while the queue is empty.
    always_comb begin
        stall_o       = full;
        valid_o       = ~empty;
        count_o       = count_q;
        flush_drops_o = flush_drops_q;
        pc_o          = '0;
        instr_o       = '0;
        kanata_id_o   = '0;
        if (!empty) begin
            pc_o        = mem_q[rd_ptr_q].pc;
            instr_o     = mem_q[rd_ptr_q].instr;
            kanata_id_o = mem_q[rd_ptr_q].kanata_id;
        end
    end

    // Structural invariants of the queue.
    a_no_enq_full: assert property (@(posedge clk_i) disable iff (rst_i) enq |-> !full);
    a_no_deq_empty: assert property (@(posedge clk_i) disable iff (rst_i) deq |-> !empty);
    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i) count_q <= FULL_COUNT);
    a_ptr_count: assert property (@(posedge clk_i) disable iff (rst_i)
        full ? (wr_ptr_q == rd_ptr_q)
             : (count_q[PTR_W-1:0] == PTR_W'(wr_ptr_q - rd_ptr_q)));

endmodule
